sequential_elevator: RTL and testbench
======================================

# sequential_elevator

Three-floor elevator controller. It latches hall/car floor requests, decides the travel direction, and tracks the car position from an arrival sensor. It drives per-floor position LEDs, a 2-bit direction code and a door-open command. It sits between the button/sensor inputs and the motor/door drivers and LED panel; all outputs are registered.

## Interface
- `DOOR_CYCLES`, default 4: number of clock cycles the door stays open at a served floor (≥1).
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `floor_button1` / `floor_button2` / `floor_button3` in 1 each: request for floor 1 / 2 / 3; sampled each rising edge; a one-cycle pulse suffices.
- `elevator_arrived` in 1: shaft sensor; high on a rising edge while moving means the car has reached the next floor in the travel direction.
- `floor1_led` / `floor2_led` / `floor3_led` out 1 each: one-hot current floor.
- `elevator_direction` out 2: 00 stationary, 01 up, 10 down; 11 is never driven.
- `door_open` out 1: door command; high only while stationary at a floor.

## Operation
- State: current floor (1..3), 3-bit pending-request register, FSM state, door timer.
- FSM states:
  - IDLE: direction 00, door 0.
  - MOVE_UP: direction 01, door 0.
  - MOVE_DOWN: direction 10, door 0.
  - DOOR: direction 00, door 1.
- Request latch:
  - Any button high on an edge sets its pending bit.
  - Exception: the button for the current floor while in IDLE or DOOR. It is not latched.
    - In IDLE it causes entry to DOOR.
    - In DOOR it restarts the door timer.
- Decision rule, evaluated in IDLE and at the end of DOOR:
  - Requests above the current floor only → MOVE_UP.
  - Requests below only → MOVE_DOWN.
  - Both above and below → keep the last travel direction; initial last direction after reset is up.
  - None → IDLE.
- MOVE_UP / MOVE_DOWN:
  - On an edge with `elevator_arrived`=1, current floor ±1 (saturating at 1 and 3).
  - If the new floor is pending, clear its bit and go to DOOR.
  - Otherwise stay moving.
  - With `elevator_arrived`=0, hold state and floor.
- DOOR:
  - Timer loads DOOR_CYCLES on entry and decrements each edge.
  - On the edge where it would reach 0, door closes and the decision rule selects the next state directly.
- `elevator_arrived` is ignored in IDLE and DOOR.
- Simultaneous buttons: all are latched in the same edge. Service order follows the decision rule (nearest in the current direction first).
- Reset (asynchronous): floor 1 (`floor1_led`=1, others 0), IDLE, direction 00, door 0, requests cleared, last direction up, timer 0. Reset mid-travel abandons all requests.

## Timing
- Button high at edge k → pending bit visible at edge k. From IDLE, direction becomes 01/10 at edge k+1.
- Arrival sampled at edge m in a MOVE state → LED change at edge m. If that floor is pending, door_open=1 and direction=00 also at edge m.
- door_open is high from edge m through edge m+DOOR_CYCLES−1, low at edge m+DOOR_CYCLES. The next direction is valid at that same edge.
- Exactly one floor LED is high at all times after reset.
- direction≠00 implies door_open=0.
- With `elevator_arrived` held high, the car advances one floor per cycle.

## Test plan
- Reset, then idle 5 cycles → floor1_led=1, others 0, direction=00, door_open=0.
- Pulse floor_button2 one cycle, then hold `elevator_arrived`=1:
  - direction=01 the next cycle.
  - One edge later floor2_led=1, direction=00, door_open=1.
  - Door stays open exactly 4 cycles, then door_open=0, direction=00.
- At floor 2, pulse floor_button3 with `elevator_arrived` high → up one floor, floor3_led=1, door open 4 cycles.
- At floor 3, pulse floor_button1 with `elevator_arrived` held 0:
  - direction=10 held, floor3_led stays.
  - Raise `elevator_arrived` → floor2_led (no stop), then floor1_led with door_open=1.
- At floor 2 moving up toward a pending 3, press button 1:
  - Floor 3 is served first, then direction=10.
  - Floor 1 is served; floors are never skipped.
- Assert `rst` mid-move (direction=01, door 0) → immediate floor1_led=1, direction=00, door_open=0; pending requests are gone (no movement afterwards).

Source files
------------

// File: rtl/sequential_elevator.sv
`default_nettype none
// ============================================================================
// Module      : sequential_elevator
// Description : Three-floor elevator controller. Latches floor requests,
//               chooses travel direction, tracks car position from the
//               arrival sensor, and drives registered LED/direction/door
//               outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module sequential_elevator #(
  parameter int DOOR_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       floor_button1,
  input  logic       floor_button2,
  input  logic       floor_button3,
  input  logic       elevator_arrived,
  output logic       floor1_led,
  output logic       floor2_led,
  output logic       floor3_led,
  output logic [1:0] elevator_direction,
  output logic       door_open
);

  localparam int            TW          = (DOOR_CYCLES < 1) ? 1 : $clog2(DOOR_CYCLES + 1);
  localparam logic [TW-1:0] C_DOOR_LOAD = TW'(DOOR_CYCLES);
  localparam logic [TW-1:0] C_ONE       = TW'(1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR      = 2'd3
  } state_t;

  // Registered state; request bit i corresponds to floor i+1
  state_t        state_q, state_d;
  logic [1:0]    floor_q, floor_d;
  logic [2:0]    req_q, req_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          last_up_q, last_up_d;
  logic [2:0]    leds_q;
  logic [1:0]    dir_q;
  logic          door_q;

  // Combinational helpers
  logic [2:0]    w_btn;
  logic [2:0]    w_cur_oh;
  logic [2:0]    w_next_oh;
  logic          w_hit;
  logic          w_above;
  logic          w_below;
  state_t        w_dec_state;
  logic          w_dec_last_up;

  function automatic logic [2:0] floor_onehot(input logic [1:0] f);
    case (f)
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  assign w_btn    = {floor_button3, floor_button2, floor_button1};
  assign w_cur_oh = floor_onehot(floor_q);
  assign w_hit    = |(w_btn & w_cur_oh);

  // Classify latched requests relative to the current floor
  always_comb begin
    w_above = 1'b0;
    w_below = 1'b0;
    case (floor_q)
      2'd1: w_above = req_q[1] | req_q[2];
      2'd2: begin
        w_above = req_q[2];
        w_below = req_q[0];
      end
      2'd3: w_below = req_q[0] | req_q[1];
      default: ;
    endcase
  end

  // Direction decision: single-sided requests pick that side, two-sided keep heading
  always_comb begin
    w_dec_state   = ST_IDLE;
    w_dec_last_up = last_up_q;
    if (w_above && !w_below) begin
      w_dec_state   = ST_MOVE_UP;
      w_dec_last_up = 1'b1;
    end else if (w_below && !w_above) begin
      w_dec_state   = ST_MOVE_DOWN;
      w_dec_last_up = 1'b0;
    end else if (w_above && w_below) begin
      w_dec_state   = last_up_q ? ST_MOVE_UP : ST_MOVE_DOWN;
    end
  end

  // Next-state logic for FSM, floor, request latch and door timer
  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    req_d     = req_q | w_btn;
    timer_d   = timer_q;
    last_up_d = last_up_q;
    w_next_oh = 3'b000;
    case (state_q)
      ST_IDLE, ST_DOOR: begin
        // The current-floor button opens / holds the door instead of latching
        req_d = req_q | (w_btn & ~w_cur_oh);
        if (w_hit) begin
          state_d = ST_DOOR;
          timer_d = C_DOOR_LOAD;
        end else if (state_q == ST_DOOR && timer_q > C_ONE) begin
          timer_d = timer_q - C_ONE;
        end else begin
          // Idle, or last door cycle: the decision picks the next state directly
          timer_d   = '0;
          state_d   = w_dec_state;
          last_up_d = w_dec_last_up;
        end
      end
      ST_MOVE_UP, ST_MOVE_DOWN: begin
        if (elevator_arrived) begin
          if (state_q == ST_MOVE_UP) begin
            floor_d = (floor_q == 2'd3) ? floor_q : floor_q + 2'd1;
          end else begin
            floor_d = (floor_q == 2'd1) ? floor_q : floor_q - 2'd1;
          end
          w_next_oh = floor_onehot(floor_d);
          if (|(req_d & w_next_oh)) begin
            req_d   = req_d & ~w_next_oh;
            state_d = ST_DOOR;
            timer_d = C_DOOR_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; outputs are registered from the next-state values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      floor_q   <= 2'd1;
      req_q     <= 3'b000;
      timer_q   <= '0;
      last_up_q <= 1'b1;
      leds_q    <= 3'b001;
      dir_q     <= 2'b00;
      door_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      req_q     <= req_d;
      timer_q   <= timer_d;
      last_up_q <= last_up_d;
      leds_q    <= floor_onehot(floor_d);
      dir_q     <= (state_d == ST_MOVE_UP)   ? 2'b01 :
                   (state_d == ST_MOVE_DOWN) ? 2'b10 : 2'b00;
      door_q    <= (state_d == ST_DOOR);
    end
  end

  assign floor1_led         = leds_q[0];
  assign floor2_led         = leds_q[1];
  assign floor3_led         = leds_q[2];
  assign elevator_direction = dir_q;
  assign door_open          = door_q;

endmodule
`default_nettype wire

// File: tb/tb_sequential_elevator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sequential_elevator
// Description : Self-checking bench for sequential_elevator: directed
//               scenarios with literal expectations plus random stimulus
//               compared each cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sequential_elevator;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic       b1, b2, b3;
  logic       arr;
  logic       led1, led2, led3;
  logic [1:0] dir;
  logic       door;
  logic       chk_en;

  int vectors;
  int miscompares;

  sequential_elevator #(.DOOR_CYCLES(D)) dut (
    .clk                (clk),
    .rst                (rst),
    .floor_button1      (b1),
    .floor_button2      (b2),
    .floor_button3      (b3),
    .elevator_arrived   (arr),
    .floor1_led         (led1),
    .floor2_led         (led2),
    .floor3_led         (led3),
    .elevator_direction (dir),
    .door_open          (door)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // m_pos: floor number, m_pend[f]: floor f requested, m_dir: 0 still/1 up/2 down,
  // m_door: door cycles left (0 = closed)
  int       m_pos;
  bit [3:1] m_pend;
  int       m_dir;
  int       m_door;
  bit       m_last_up;

  task automatic m_step(input bit [3:1] btn, input bit a);
    bit [3:1] old;
    int up_cnt, dn_cnt;
    old    = m_pend;
    up_cnt = 0;
    dn_cnt = 0;
    for (int f = 1; f <= 3; f++) begin
      if (old[f] && f > m_pos) up_cnt++;
      if (old[f] && f < m_pos) dn_cnt++;
    end
    if (m_dir == 0) begin
      for (int f = 1; f <= 3; f++)
        if (btn[f] && f != m_pos) m_pend[f] = 1'b1;
      if (btn[m_pos]) begin
        m_door = D;
      end else if (m_door > 1) begin
        m_door = m_door - 1;
      end else begin
        m_door = 0;
        if (up_cnt > 0 && dn_cnt == 0) begin
          m_dir = 1; m_last_up = 1'b1;
        end else if (dn_cnt > 0 && up_cnt == 0) begin
          m_dir = 2; m_last_up = 1'b0;
        end else if (up_cnt > 0 && dn_cnt > 0) begin
          m_dir = m_last_up ? 1 : 2;
        end
      end
    end else begin
      m_pend = m_pend | btn;
      if (a) begin
        m_pos = m_pos + ((m_dir == 1) ? 1 : -1);
        if (m_pos > 3) m_pos = 3;
        if (m_pos < 1) m_pos = 1;
        if (m_pend[m_pos]) begin
          m_pend[m_pos] = 1'b0;
          m_dir  = 0;
          m_door = D;
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos = 1; m_pend = '0; m_dir = 0; m_door = 0; m_last_up = 1'b1;
    end else begin
      m_step({b3, b2, b1}, arr);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string name, input logic [2:0] led_e,
                            input logic [1:0] dir_e, input logic door_e);
    check({name, "_led"},  {led3, led2, led1}, led_e);
    check({name, "_dir"},  {1'b0, dir},        {1'b0, dir_e});
    check({name, "_door"}, {2'b00, door},      {2'b00, door_e});
  endtask

  // Remaining D-1 cycles of an open door at a fixed floor
  task automatic door_hold(input string name, input logic [2:0] led_e);
    for (int i = 1; i < D; i++) begin
      @(negedge clk);
      expect_out(name, led_e, 2'b00, 1'b1);
    end
  endtask

  // Model comparison on every cycle outside reset
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("mdl_led",  {led3, led2, led1}, 3'b001 << (m_pos - 1));
      check("mdl_dir",  {1'b0, dir},        3'(m_dir));
      check("mdl_door", {2'b00, door},      {2'b00, (m_door > 0)});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    vectors = 0; miscompares = 0; chk_en = 1'b0;
    rst = 1'b1; b1 = 1'b0; b2 = 1'b0; b3 = 1'b0; arr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; chk_en = 1'b1;
    repeat (5) @(negedge clk);
    expect_out("reset_idle", 3'b001, 2'b00, 1'b0);

    // Floor 1 -> 2 with arrival held high
    b2 = 1'b1; arr = 1'b1;
    @(negedge clk); b2 = 1'b0;
    expect_out("s2_latch", 3'b001, 2'b00, 1'b0);
    @(negedge clk); expect_out("s2_up", 3'b001, 2'b01, 1'b0);
    @(negedge clk); expect_out("s2_arrive", 3'b010, 2'b00, 1'b1);
    door_hold("s2_door", 3'b010);
    @(negedge clk); expect_out("s2_close", 3'b010, 2'b00, 1'b0);

    // Floor 2 -> 3
    b3 = 1'b1;
    @(negedge clk); b3 = 1'b0;
    expect_out("s3_latch", 3'b010, 2'b00, 1'b0);
    @(negedge clk); expect_out("s3_up", 3'b010, 2'b01, 1'b0);
    @(negedge clk); expect_out("s3_arrive", 3'b100, 2'b00, 1'b1);
    door_hold("s3_door", 3'b100);
    @(negedge clk); expect_out("s3_close", 3'b100, 2'b00, 1'b0);

    // Floor 3 -> 1, sensor held low first, pass floor 2 without stopping
    arr = 1'b0; b1 = 1'b1;
    @(negedge clk); b1 = 1'b0;
    expect_out("s4_latch", 3'b100, 2'b00, 1'b0);
    @(negedge clk); expect_out("s4_down", 3'b100, 2'b10, 1'b0);
    repeat (3) begin
      @(negedge clk); expect_out("s4_wait", 3'b100, 2'b10, 1'b0);
    end
    arr = 1'b1;
    @(negedge clk); expect_out("s4_pass2", 3'b010, 2'b10, 1'b0);
    @(negedge clk); expect_out("s4_arrive1", 3'b001, 2'b00, 1'b1);
    door_hold("s4_door", 3'b001);
    @(negedge clk); expect_out("s4_close", 3'b001, 2'b00, 1'b0);

    // Up toward 3, press 1 while at floor 2: serve 3 first, then back down to 1
    b3 = 1'b1;
    @(negedge clk); b3 = 1'b0;
    @(negedge clk); expect_out("s5_up", 3'b001, 2'b01, 1'b0);
    @(negedge clk); expect_out("s5_pass2", 3'b010, 2'b01, 1'b0);
    b1 = 1'b1;
    @(negedge clk); b1 = 1'b0;
    expect_out("s5_arrive3", 3'b100, 2'b00, 1'b1);
    door_hold("s5_door3", 3'b100);
    @(negedge clk); expect_out("s5_turn", 3'b100, 2'b10, 1'b0);
    @(negedge clk); expect_out("s5_pass2dn", 3'b010, 2'b10, 1'b0);
    @(negedge clk); expect_out("s5_arrive1", 3'b001, 2'b00, 1'b1);
    door_hold("s5_door1", 3'b001);
    @(negedge clk); expect_out("s5_close", 3'b001, 2'b00, 1'b0);

    // Reset mid-move abandons requests
    arr = 1'b0; b3 = 1'b1;
    @(negedge clk); b3 = 1'b0;
    @(negedge clk); expect_out("s6_moving", 3'b001, 2'b01, 1'b0);
    b2 = 1'b1;
    #1 rst = 1'b1;
    #1 expect_out("s6_rst", 3'b001, 2'b00, 1'b0);
    b2 = 1'b0;
    #1 rst = 1'b0;
    arr = 1'b1;
    repeat (5) begin
      @(negedge clk); expect_out("s6_after", 3'b001, 2'b00, 1'b0);
    end

    // Randomized traffic against the model
    repeat (3000) begin
      @(negedge clk);
      b1  = ($urandom_range(0, 7) == 0);
      b2  = ($urandom_range(0, 7) == 0);
      b3  = ($urandom_range(0, 7) == 0);
      arr = ($urandom_range(0, 1) == 1);
    end
    @(negedge clk);
    b1 = 1'b0; b2 = 1'b0; b3 = 1'b0; arr = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
